// File: rtl/note_highway_vga.sv
// Note-highway renderer for a 640x480 VGA timing: scrolling beat slots whose lane masks
// come from a writable pattern RAM, with registered outputs and per-lane strike-line hit strobes.
module note_highway_vga #(
  parameter int NUM_LANES    = 4,
  parameter int NUM_SLOTS    = 4,
  parameter int SLOT_SPACING = 160,
  parameter int NOTE_LEN     = 150,
  parameter int PAT_DEPTH    = 16,
  parameter int STRIKE_X     = 600,
  parameter int HPIXELS      = 640,
  parameter int HFP          = 16,
  parameter int HPULSE       = 96,
  parameter int HBP          = 48,
  parameter int VLINES       = 480,
  parameter int VFP          = 10,
  parameter int VPULSE       = 2,
  parameter int VBP          = 33,
  localparam int AW          = $clog2(PAT_DEPTH)
) (
  input  logic                 vgaclk,
  input  logic                 rst,
  input  logic [3:0]           speed,
  input  logic                 pause,
  input  logic                 pat_wr_en,
  input  logic [AW-1:0]        pat_wr_addr,
  input  logic [NUM_LANES-1:0] pat_wr_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic [3:0]           red,
  output logic [3:0]           green,
  output logic [3:0]           blue,
  output logic                 blank,
  output logic                 frame_tick,
  output logic [NUM_LANES-1:0] hit
);

  localparam int HTOTAL = HPIXELS + HFP + HPULSE + HBP;
  localparam int VTOTAL = VLINES + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(HTOTAL + NOTE_LEN + SLOT_SPACING * NUM_SLOTS + 16);
  localparam int VW     = $clog2(VTOTAL);
  localparam int LW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [XW-1:0] H_LAST  = XW'(HTOTAL - 1);
  localparam logic [XW-1:0] H_ACT   = XW'(HPIXELS);
  localparam logic [XW-1:0] HS_ON   = XW'(HPIXELS + HFP);
  localparam logic [XW-1:0] HS_OFF  = XW'(HPIXELS + HFP + HPULSE);
  localparam logic [XW-1:0] SX_LO   = XW'(STRIKE_X);
  localparam logic [XW-1:0] SX_HI   = XW'(STRIKE_X + 2);
  localparam logic [XW-1:0] NLEN    = XW'(NOTE_LEN);
  localparam logic [XW-1:0] WRAP_AT = XW'(HPIXELS + NOTE_LEN - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(VLINES);
  localparam logic [VW-1:0] VS_ON   = VW'(VLINES + VFP);
  localparam logic [VW-1:0] VS_OFF  = VW'(VLINES + VFP + VPULSE);
  localparam logic [VW-1:0] LANE_H  = VW'(VLINES / NUM_LANES);
  localparam logic [VW-1:0] N_LANES = VW'(NUM_LANES);

  logic [XW-1:0]        hc;
  logic [VW-1:0]        vc;
  logic [VW-1:0]        lane;
  logic                 tick_now;
  logic                 frame_upd;
  logic [XW-1:0]        pos      [NUM_SLOTS];
  logic [AW-1:0]        ptr      [NUM_SLOTS];
  logic [NUM_LANES-1:0] mask     [NUM_SLOTS];
  logic [XW-1:0]        adv      [NUM_SLOTS];
  logic [XW-1:0]        new_pos  [NUM_SLOTS];
  logic [AW-1:0]        new_ptr  [NUM_SLOTS];
  logic                 wrap     [NUM_SLOTS];
  logic [NUM_LANES-1:0] ram      [PAT_DEPTH];
  logic [NUM_LANES-1:0] hit_nxt;
  logic [11:0]          rgb_nxt;
  logic [11:0]          lane_rgb;
  logic                 found;

  assign tick_now  = (hc == '0) && (vc == VS_ON);
  assign frame_upd = tick_now && !pause;
  assign lane      = vc / LANE_H;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + XW'(1);
    end
  end

  always_comb begin
    hit_nxt = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      adv[s]     = pos[s] + XW'(speed);
      wrap[s]    = adv[s] >= WRAP_AT;
      new_pos[s] = wrap[s] ? '0 : adv[s];
      new_ptr[s] = ptr[s] + AW'(NUM_SLOTS);
      if (frame_upd && pos[s] < SX_LO && SX_LO <= new_pos[s])
        hit_nxt = hit_nxt | mask[s];
    end
  end

  // The wrap read below sees the RAM before any same-edge write lands (read-before-write).
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        pos[s]  <= XW'(s * SLOT_SPACING);
        ptr[s]  <= AW'(s % PAT_DEPTH);
        mask[s] <= '0;
      end
    end else if (frame_upd) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        pos[s] <= new_pos[s];
        if (wrap[s]) begin
          ptr[s]  <= new_ptr[s];
          mask[s] <= ram[new_ptr[s]];
        end
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (pat_wr_en)
      ram[pat_wr_addr] <= pat_wr_data;
  end

  always_comb begin
    case (lane[1:0])
      2'd0:    lane_rgb = 12'hFF0;
      2'd1:    lane_rgb = 12'h00F;
      2'd2:    lane_rgb = 12'h0F0;
      default: lane_rgb = 12'hF00;
    endcase
  end

  // Ascending scan with a found flag gives the lowest-index slot priority.
  always_comb begin
    rgb_nxt = '0;
    found   = 1'b0;
    if (hc < H_ACT && vc < V_ACT) begin
      if (hc >= SX_LO && hc < SX_HI) begin
        rgb_nxt = 12'h888;
      end else begin
        rgb_nxt = 12'hFFF;
        if (lane < N_LANES) begin
          for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            if (!found && hc <= pos[s] && hc + NLEN > pos[s] && mask[s][lane[LW-1:0]]) begin
              found   = 1'b1;
              rgb_nxt = lane_rgb;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      {red, green, blue} <= '0;
      hsync              <= 1'b1;
      vsync              <= 1'b1;
      blank              <= 1'b1;
      frame_tick         <= 1'b0;
      hit                <= '0;
    end else begin
      {red, green, blue} <= rgb_nxt;
      hsync              <= !(hc >= HS_ON && hc < HS_OFF);
      vsync              <= !(vc >= VS_ON && vc < VS_OFF);
      blank              <= !(hc < H_ACT && vc < V_ACT);
      frame_tick         <= tick_now;
      hit                <= hit_nxt;
    end
  end

endmodule

// File: tb/tb_note_highway_vga.sv
// Randomized bench for note_highway_vga on a shrunken timing so many frames fit in a short run;
// expected outputs come from a cycle-count based model of the renderer.
module tb_note_highway_vga;

  localparam int NL = 4, NS = 4, SP = 10, LEN = 8, PD = 16, SX = 24;
  localparam int HP = 32, HFP = 4, HPW = 6, HBP = 2;
  localparam int VL = 16, VFP = 2, VPW = 2, VBP = 2;
  localparam int HT = HP + HFP + HPW + HBP;
  localparam int VT = VL + VFP + VPW + VBP;
  localparam int WRAP = HP + LEN - 1;
  localparam int FRAME = HT * VT;

  logic          vgaclk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    speed = '0;
  logic          pause = 1'b0;
  logic          pat_wr_en = 1'b0;
  logic [3:0]    pat_wr_addr = '0;
  logic [NL-1:0] pat_wr_data = '0;
  logic          hsync, vsync, blank, frame_tick;
  logic [3:0]    red, green, blue;
  logic [NL-1:0] hit;

  note_highway_vga #(
    .NUM_LANES(NL), .NUM_SLOTS(NS), .SLOT_SPACING(SP), .NOTE_LEN(LEN), .PAT_DEPTH(PD),
    .STRIKE_X(SX), .HPIXELS(HP), .HFP(HFP), .HPULSE(HPW), .HBP(HBP),
    .VLINES(VL), .VFP(VFP), .VPULSE(VPW), .VBP(VBP)
  ) dut (
    .vgaclk(vgaclk), .rst(rst), .speed(speed), .pause(pause),
    .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .blank(blank), .frame_tick(frame_tick), .hit(hit)
  );

  always #5 vgaclk = ~vgaclk;

  int            n_vec = 0, n_bad = 0;
  int            t = 0;
  int            mpos [NS];
  int            mptr [NS];
  logic [NL-1:0] mmask [NS];
  logic [NL-1:0] mram [PD];
  int            e_rgb, e_hs, e_vs, e_bl, e_ft;
  logic [NL-1:0] e_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0d: got %h, want %h", tag, t, got, exp);
    end
  endtask

  function automatic int pixel(input int hc, input int vc);
    int lane;
    if (!(hc < HP && vc < VL)) return 0;
    if (hc == SX || hc == SX + 1) return 'h888;
    lane = vc / (VL / NL);
    if (lane < NL)
      for (int s = 0; s < NS; s++)
        if (hc <= mpos[s] && hc + LEN > mpos[s] && mmask[s][lane])
          case (lane % 4)
            0: return 'hFF0;
            1: return 'h00F;
            2: return 'h0F0;
            default: return 'hF00;
          endcase
    return 'hFFF;
  endfunction

  task automatic predict();
    int hc, vc, np;
    hc = t % HT;
    vc = (t / HT) % VT;
    e_hit = '0;
    if (rst) begin
      e_rgb = 0; e_hs = 1; e_vs = 1; e_bl = 1; e_ft = 0;
      return;
    end
    e_hs  = (hc >= HP + HFP && hc < HP + HFP + HPW) ? 0 : 1;
    e_vs  = (vc >= VL + VFP && vc < VL + VFP + VPW) ? 0 : 1;
    e_bl  = (hc < HP && vc < VL) ? 0 : 1;
    e_ft  = (hc == 0 && vc == VL + VFP) ? 1 : 0;
    e_rgb = pixel(hc, vc);
    if (e_ft == 1 && !pause)
      for (int s = 0; s < NS; s++) begin
        np = mpos[s] + int'(speed);
        if (np >= WRAP) np = 0;
        if (mpos[s] < SX && SX <= np) e_hit = e_hit | mmask[s];
      end
  endtask

  task automatic advance();
    int hc, vc, np;
    hc = t % HT;
    vc = (t / HT) % VT;
    if (rst) begin
      t = 0;
      for (int s = 0; s < NS; s++) begin
        mpos[s] = s * SP; mptr[s] = s % PD; mmask[s] = '0;
      end
    end else begin
      if (hc == 0 && vc == VL + VFP && !pause)
        for (int s = 0; s < NS; s++) begin
          np = mpos[s] + int'(speed);
          if (np >= WRAP) begin
            mpos[s]  = 0;
            mptr[s]  = (mptr[s] + NS) % PD;
            mmask[s] = mram[mptr[s]];
          end else begin
            mpos[s] = np;
          end
        end
      t++;
    end
    if (pat_wr_en) mram[pat_wr_addr] = pat_wr_data;
  endtask

  task automatic step();
    predict();
    @(posedge vgaclk);
    #1;
    check("rgb", 32'({red, green, blue}), 32'(e_rgb));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("blank", 32'(blank), 32'(e_bl));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
    check("hit", 32'(hit), 32'(e_hit));
    advance();
  endtask

  task automatic run(input int n);
    int hc, vc;
    for (int i = 0; i < n; i++) begin
      hc = t % HT;
      vc = (t / HT) % VT;
      pat_wr_en = 1'b0;
      if (hc == 0 && vc == 0) begin
        if ($urandom_range(0, 3) == 0) pause = ~pause;
        if ($urandom_range(0, 2) == 0) speed = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) speed = '0;
      end
      if ($urandom_range(0, 499) == 0) speed = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        pat_wr_en = 1'b1; pat_wr_addr = 4'($urandom); pat_wr_data = NL'($urandom);
      end
      // occasionally overwrite the entry a wrapping slot is about to load
      if (hc == 0 && vc == VL + VFP && !pause && $urandom_range(0, 1) == 1)
        for (int s = 0; s < NS; s++)
          if (mpos[s] + int'(speed) >= WRAP) begin
            pat_wr_en   = 1'b1;
            pat_wr_addr = 4'((mptr[s] + NS) % PD);
            pat_wr_data = NL'($urandom);
          end
      step();
    end
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int a = 0; a < PD; a++) begin
      pat_wr_en = 1'b1; pat_wr_addr = a[3:0]; pat_wr_data = NL'($urandom_range(1, 15));
      step();
    end
    pat_wr_en = 1'b0;
    speed = 4'd3;
    run(20 * FRAME);

    waited = 0;
    while (!((t % HT) == 20 && ((t / HT) % VT) == 8) && waited < 2 * FRAME) begin
      run(1);
      waited++;
    end
    check("rst_wait", 32'(waited < 2 * FRAME), 32'(1));
    pat_wr_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(25 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
